rob_param: RTL and testbench
============================

# rob_param

Parametrised reorder buffer: the next-generation replacement for the core's fixed 32-entry, 3-writeback ROB. It allocates entries in program order at rename, accepts out-of-order results from `NUM_WB` functional-unit writeback ports, and retires completed entries in order through a ready/valid commit port that drives regfile write and rename free. Unlike its predecessor, it has backpressure on both ends, occupancy reporting, and precise partial squash after a given entry, so branches flush speculatively fetched instructions instead of stalling fetch.

## Interface
Parameters:
- `DEPTH`, 32: number of entries. Must be a power of two and ≥ 4.
- `IDX_W`, `$clog2(DEPTH)`: entry index width. Derived; do not override.
- `PREG_W`, 5: physical destination register address width.
- `DATA_W`, 32: result width.
- `NUM_WB`, 3: number of writeback ports.

Ports:
- `clk_i` in 1: clock. All state updates on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `alloc_valid_i` in 1: allocation request.
- `alloc_ready_o` out 1: allocation is accepted this cycle.
- `alloc_prd_i` in `PREG_W`: destination physical register of the new entry.
- `alloc_pc_i` in 32: PC of the new entry.
- `alloc_idx_o` out `IDX_W`: index assigned to the requesting entry (tail).
- `wb_valid_i` in `NUM_WB`: per-port writeback strobe.
- `wb_idx_i` in `NUM_WB*IDX_W`: per-port target index. Port k occupies bits `[k*IDX_W +: IDX_W]`.
- `wb_data_i` in `NUM_WB*DATA_W`: per-port result, packed the same way.
- `flush_i` in 1: squash every entry younger than `flush_idx_i`.
- `flush_idx_i` in `IDX_W`: last surviving entry. Must be an occupied entry.
- `flush_all_i` in 1: squash every entry.
- `commit_valid_o` out 1: head entry is complete.
- `commit_ready_i` in 1: consumer accepts the head entry.
- `commit_idx_o` out `IDX_W`: head index.
- `commit_prd_o` out `PREG_W`: head destination register.
- `commit_data_o` out `DATA_W`: head result.
- `commit_pc_o` out 32: head PC.
- `empty_o` out 1, `full_o` out 1, `count_o` out `IDX_W+1`: occupancy.

## Operation
- **Pointers.** `head` and `tail` are `IDX_W+1` bits wide; the MSB is a wrap bit.
  - `count = tail - head`, computed modulo 2^(IDX_W+1).
  - `full` is `count == DEPTH`; `empty` is `count == 0`.
- **Per-entry state:** `valid`, `done`, `prd`, `pc`, `data`.
- **Allocate.** `alloc_ready_o = !full && !flush_i && !flush_all_i`. On accept:
  - the entry at `tail` is written with `valid=1`, `done=0`, `prd`, `pc`;
  - `tail` increments.
- **Writeback.** For each k with `wb_valid_i[k]` set and the target entry valid: `done=1` and `data` is written.
  - A strobe to an invalid entry is ignored.
  - If two ports hit the same index in one cycle, the higher port number wins.
- **Commit.** `commit_valid_o = valid[head] && done[head]`.
  - Fire when `commit_valid_o && commit_ready_i`: the head entry is cleared and `head` increments.
  - Commit outputs come combinationally from the head entry; values are don't-care when `commit_valid_o=0`.
- **Flush.**
  - Offset: `off = (flush_idx_i - head[IDX_W-1:0]) mod DEPTH`.
  - New tail: `tail <= head + off + 1`, full `IDX_W+1`-bit add, so the wrap bit is correct.
  - Entries from `off+1` up to the old count are invalidated.
- **Flush all.** `tail <= head` and every `valid` is cleared.
- **Priority,** highest first: `flush_all_i`, `flush_i`, allocate. Writeback and commit proceed in the same cycle as a flush.
  - A writeback to a squashed entry is dropped.
  - A commit in the same cycle as `flush_all_i` still retires the head. `head` advances and `tail` is set to the new `head`.

## Timing
- **Reset values:**
  - `head = tail = 0`; all `valid = done = 0`.
  - `empty_o=1`, `full_o=0`, `count_o=0`, `alloc_ready_o=1`, `alloc_idx_o=0`, `commit_valid_o=0`.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- **Allocate:** `alloc_idx_o` is valid combinationally in the request cycle; the entry exists from the next edge.
- **Writeback to commit:** an entry written back at edge N shows `commit_valid_o=1` in cycle N+1. There is no same-cycle bypass.
  - Minimum allocate-to-retire latency is 2 edges.
- **Full and commit in the same cycle:** no allocation is accepted that cycle, because `alloc_ready_o` uses the registered count. The freed slot is usable next cycle.
- **Empty and allocate in the same cycle:** `commit_valid_o` stays 0, since the new entry is not done.
- **Wrap-around:** indices wrap `DEPTH-1 → 0` and the wrap bit toggles. `count_o` stays correct across the wrap.
- **Status outputs:** `count_o`, `empty_o` and `full_o` reflect registered pointers only.

## Test plan
- **Reset and fill:** with `DEPTH=4`, release reset and allocate 5 times → indices 0,1,2,3 accepted; `full_o=1`, `count_o=4`; the 5th request sees `alloc_ready_o=0`.
- **Out-of-order writeback:** allocate 0,1,2; write back 2 on port 0 (data 0x22), then 0 on port 2 (0x00), then 1 on port 1 (0x11) → commits in order 0,1,2 with data 0x00,0x11,0x22; each commit appears one cycle after its writeback at the earliest.
- **Port collision:** ports 0 and 2 write index 1 in the same cycle with 0xAA and 0xBB → commit of index 1 carries 0xBB.
- **Partial flush across wrap:** `DEPTH=4`, `head=3`, entries 3,0,1,2 occupied; `flush_i` with `flush_idx_i=0` → `count_o=2`, `tail=head+2`; a later writeback to index 1 is ignored; the next `alloc_idx_o=1`.
- **Backpressure and flush_all:** hold `commit_ready_i=0` with the head done → `commit_valid_o` stays 1 and the head does not advance. Then pulse `flush_all_i` with `commit_ready_i=1` → the head retires and `empty_o=1` next cycle.
- **Async reset mid-stream:** drop `reset_i` between clock edges with 3 entries live → `empty_o=1` and `commit_valid_o=0` immediately, before the next edge.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback over
// NUM_WB ports, in-order ready/valid commit, partial and full squash.
// Head/tail carry an extra wrap bit so full and empty are distinguishable.

// One ROB slot: holds valid/done/prd/pc/data and resolves its own writeback
// hits across all ports (highest port number wins on a collision).
module rob_param_entry #(
    parameter int IDX    = 0,
    parameter int IDX_W  = 5,
    parameter int PREG_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_WB = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc,
    input  logic [PREG_W-1:0]          alloc_prd,
    input  logic [31:0]                alloc_pc,
    input  logic                       kill,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
    output logic                       valid,
    output logic                       done,
    output logic [PREG_W-1:0]          prd,
    output logic [31:0]                pc,
    output logic [DATA_W-1:0]          data
);
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    // Scan ports low to high so a later (higher) port overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == IDX_W'(IDX))) begin
                hit      = 1'b1;
                hit_data = wb_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Squash/retire beats allocate beats writeback; writeback needs a live entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            done  <= 1'b0;
            prd   <= '0;
            pc    <= '0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (alloc) begin
            valid <= 1'b1;
            done  <= 1'b0;
            prd   <= alloc_prd;
            pc    <= alloc_pc;
        end else if (valid && hit) begin
            done  <= 1'b1;
            data  <= hit_data;
        end
    end
endmodule

module rob_param #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int PREG_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_WB = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [PREG_W-1:0]          alloc_prd_i,
    input  logic [31:0]                alloc_pc_i,
    output logic [IDX_W-1:0]           alloc_idx_o,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]    wb_idx_i,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data_i,
    input  logic                       flush_i,
    input  logic [IDX_W-1:0]           flush_idx_i,
    input  logic                       flush_all_i,
    output logic                       commit_valid_o,
    input  logic                       commit_ready_i,
    output logic [IDX_W-1:0]           commit_idx_o,
    output logic [PREG_W-1:0]          commit_prd_o,
    output logic [DATA_W-1:0]          commit_data_o,
    output logic [31:0]                commit_pc_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [IDX_W:0]             count_o
);
    logic [IDX_W:0]                    head, tail, head_next, count;
    logic [IDX_W-1:0]                  head_idx, tail_idx, flush_off;
    logic                              alloc_fire, commit_fire;
    logic [DEPTH-1:0]                  valid, done;
    logic [DEPTH-1:0][PREG_W-1:0]      prd;
    logic [DEPTH-1:0][31:0]            pc;
    logic [DEPTH-1:0][DATA_W-1:0]      data;

    assign head_idx  = head[IDX_W-1:0];
    assign tail_idx  = tail[IDX_W-1:0];
    assign count     = tail - head;
    assign empty_o   = (count == '0);
    assign full_o    = (count == (IDX_W+1)'(DEPTH));
    assign count_o   = count;

    // Status is from registered pointers only, so a same-cycle commit never
    // opens an allocation slot until the following cycle.
    assign alloc_ready_o = !full_o && !flush_i && !flush_all_i;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_idx_o   = tail_idx;

    assign commit_valid_o = valid[head_idx] && done[head_idx];
    assign commit_fire    = commit_valid_o && commit_ready_i;
    assign commit_idx_o   = head_idx;
    assign commit_prd_o   = prd[head_idx];
    assign commit_pc_o    = pc[head_idx];
    assign commit_data_o  = data[head_idx];

    // Distance from head to the last surviving entry of a partial squash.
    assign flush_off = flush_idx_i - head_idx;
    assign head_next = head + (IDX_W+1)'(commit_fire);

    // Pointer update: flush_all > flush > allocate; commit always advances head.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_next;
            if (flush_all_i)
                tail <= head_next;
            else if (flush_i)
                tail <= head + {1'b0, flush_off} + (IDX_W+1)'(1);
            else if (alloc_fire)
                tail <= tail + (IDX_W+1)'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [IDX_W-1:0] pos;
        logic             kill;

        // An entry dies when retired, on flush_all, or when it sits past the
        // surviving offset of a partial flush (empty slots there are harmless).
        assign pos  = IDX_W'(i) - head_idx;
        assign kill = flush_all_i
                    || (flush_i && (pos > flush_off))
                    || (commit_fire && (head_idx == IDX_W'(i)));

        rob_param_entry #(
            .IDX    (i),
            .IDX_W  (IDX_W),
            .PREG_W (PREG_W),
            .DATA_W (DATA_W),
            .NUM_WB (NUM_WB)
        ) u_ent (
            .clk       (clk_i),
            .rst_n     (reset_i),
            .alloc     (alloc_fire && (tail_idx == IDX_W'(i))),
            .alloc_prd (alloc_prd_i),
            .alloc_pc  (alloc_pc_i),
            .kill      (kill),
            .wb_valid  (wb_valid_i),
            .wb_idx    (wb_idx_i),
            .wb_data   (wb_data_i),
            .valid     (valid[i]),
            .done      (done[i]),
            .prd       (prd[i]),
            .pc        (pc[i]),
            .data      (data[i])
        );
    end
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param at DEPTH=4: fill, out-of-order writeback,
// port collision, partial flush across wrap, backpressure, flush_all,
// and asynchronous reset mid-stream.
module tb_rob_param;
    localparam int DEPTH = 4, IDX_W = 2, PREG_W = 5, DATA_W = 32, NUM_WB = 3;

    logic                      clk = 1'b0;
    logic                      reset_i;
    logic                      alloc_valid, alloc_ready;
    logic [PREG_W-1:0]         alloc_prd;
    logic [31:0]               alloc_pc;
    logic [IDX_W-1:0]          alloc_idx;
    logic [NUM_WB-1:0]         wb_valid;
    logic [NUM_WB*IDX_W-1:0]   wb_idx;
    logic [NUM_WB*DATA_W-1:0]  wb_data;
    logic                      flush, flush_all;
    logic [IDX_W-1:0]          flush_idx;
    logic                      commit_valid, commit_ready;
    logic [IDX_W-1:0]          commit_idx;
    logic [PREG_W-1:0]         commit_prd;
    logic [DATA_W-1:0]         commit_data;
    logic [31:0]               commit_pc;
    logic                      empty, full;
    logic [IDX_W:0]            count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rob_param #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .alloc_valid_i  (alloc_valid),
        .alloc_ready_o  (alloc_ready),
        .alloc_prd_i    (alloc_prd),
        .alloc_pc_i     (alloc_pc),
        .alloc_idx_o    (alloc_idx),
        .wb_valid_i     (wb_valid),
        .wb_idx_i       (wb_idx),
        .wb_data_i      (wb_data),
        .flush_i        (flush),
        .flush_idx_i    (flush_idx),
        .flush_all_i    (flush_all),
        .commit_valid_o (commit_valid),
        .commit_ready_i (commit_ready),
        .commit_idx_o   (commit_idx),
        .commit_prd_o   (commit_prd),
        .commit_data_o  (commit_data),
        .commit_pc_o    (commit_pc),
        .empty_o        (empty),
        .full_o         (full),
        .count_o        (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input int k, input logic [IDX_W-1:0] idx, input logic [31:0] d);
        wb_valid[k]               = 1'b1;
        wb_idx[k*IDX_W +: IDX_W]  = idx;
        wb_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_idx   = '0;
        wb_data  = '0;
    endtask

    task automatic chk_commit(input string tag, input logic [1:0] idx, input logic [31:0] d);
        chk({tag, "_cv"},   commit_valid, 1);
        chk({tag, "_idx"},  commit_idx, idx);
        chk({tag, "_data"}, commit_data, d);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b0; alloc_valid = 0; alloc_prd = '0; alloc_pc = '0;
        flush = 0; flush_all = 0; flush_idx = '0; commit_ready = 0;
        wb_clear();
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_aready", alloc_ready, 1);
        chk("rst_aidx", alloc_idx, 0);
        chk("rst_cv", commit_valid, 0);
        @(negedge clk);
        reset_i = 1'b1;
        tick();

        // Fill: four accepted, fifth refused
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_prd = 5'(i + 1); alloc_pc = 32'h100 + 32'(4 * i);
            #1;
            chk("fill_ready", alloc_ready, 1);
            chk("fill_idx", alloc_idx, 64'(i));
            chk("fill_count", count, 64'(i));
            tick();
        end
        #1;
        chk("fill5_ready", alloc_ready, 0);
        chk("fill_full", full, 1);
        chk("fill_count4", count, 4);
        tick();
        alloc_valid = 0;
        #1;
        chk("fill_hold", count, 4);

        // Drain in order
        wb_set(0, 0, 32'hC0); wb_set(1, 1, 32'hC1); wb_set(2, 2, 32'hC2);
        #1;
        chk("drain_nobypass", commit_valid, 0);
        tick();
        wb_clear(); wb_set(0, 3, 32'hC3); commit_ready = 1;
        #1;
        chk_commit("drain0", 0, 32'hC0);
        chk("drain0_prd", commit_prd, 1);
        chk("drain0_pc", commit_pc, 32'h100);
        tick();
        wb_clear();
        #1;
        chk_commit("drain1", 1, 32'hC1);
        chk("drain1_pc", commit_pc, 32'h104);
        tick(); #1;
        chk_commit("drain2", 2, 32'hC2);
        tick(); #1;
        chk_commit("drain3", 3, 32'hC3);
        chk("drain3_pc", commit_pc, 32'h10C);
        tick(); #1;
        chk("drain_empty", empty, 1);
        chk("drain_cv", commit_valid, 0);
        chk("drain_count_wrap", count, 0);

        // Out-of-order writeback, in-order commit
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; alloc_prd = 5'(10 + i); alloc_pc = 32'h200 + 32'(4 * i);
            #1;
            chk("ooo_aidx", alloc_idx, 64'(i));
            chk("ooo_cv_alloc", commit_valid, 0);
            tick();
        end
        alloc_valid = 0;
        wb_set(0, 2, 32'h22);
        #1; chk("ooo_cv_a", commit_valid, 0);
        tick();
        wb_clear(); wb_set(2, 0, 32'h00);
        #1; chk("ooo_cv_b", commit_valid, 0);
        tick();
        wb_clear(); wb_set(1, 1, 32'h11);
        #1; chk_commit("ooo0", 0, 32'h00);
        tick();
        wb_clear();
        #1; chk_commit("ooo1", 1, 32'h11);
        tick(); #1;
        chk_commit("ooo2", 2, 32'h22);
        chk("ooo2_prd", commit_prd, 12);
        tick(); #1;
        chk("ooo_empty", empty, 1);
        commit_ready = 0;

        // Port collision on one index: port 2 wins
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; alloc_prd = 5'(i); alloc_pc = 32'h300;
            tick();
        end
        alloc_valid = 0;
        wb_set(0, 1, 32'hAA); wb_set(1, 3, 32'h33); wb_set(2, 1, 32'hBB);
        tick();
        wb_clear(); wb_set(1, 0, 32'h30); commit_ready = 1;
        #1; chk_commit("col3", 3, 32'h33);
        tick();
        wb_clear();
        #1; chk_commit("col0", 0, 32'h30);
        tick(); #1;
        chk_commit("col1", 1, 32'hBB);
        tick(); #1;
        chk("col_empty", empty, 1);
        commit_ready = 0;

        // Move head to 3
        alloc_valid = 1; alloc_prd = 5'd7; alloc_pc = 32'h3F0;
        #1; chk("adv_aidx", alloc_idx, 2);
        tick();
        alloc_valid = 0; wb_set(0, 2, 32'h5); commit_ready = 1;
        tick();
        wb_clear();
        #1; chk_commit("adv", 2, 32'h5);
        tick();
        commit_ready = 0;
        #1; chk("adv_empty", empty, 1);

        // Partial flush across wrap: entries 3,0,1,2, keep through 0
        for (int j = 0; j < 4; j++) begin
            alloc_valid = 1; alloc_prd = 5'(20 + j); alloc_pc = 32'h400 + 32'(4 * j);
            #1; chk("pf_aidx", alloc_idx, 64'((3 + j) % 4));
            tick();
        end
        alloc_valid = 0;
        #1;
        chk("pf_full", full, 1);
        flush = 1; flush_idx = 2'd0;
        #1; chk("pf_aready", alloc_ready, 0);
        tick();
        flush = 0;
        #1;
        chk("pf_count", count, 2);
        chk("pf_notfull", full, 0);
        chk("pf_cv", commit_valid, 0);
        wb_set(1, 1, 32'h77);
        tick();
        wb_clear(); alloc_valid = 1; alloc_prd = 5'd25; alloc_pc = 32'h500;
        #1;
        chk("pf_aidx_next", alloc_idx, 1);
        chk("pf_aready2", alloc_ready, 1);
        tick();
        alloc_valid = 0;
        #1; chk("pf_count3", count, 3);

        // Backpressure, then flush_all with a concurrent commit
        wb_set(0, 3, 32'h43); wb_set(1, 0, 32'h40); wb_set(2, 1, 32'h41);
        tick();
        wb_clear();
        #1;
        chk_commit("bp_a", 3, 32'h43);
        chk("bp_prd", commit_prd, 20);
        chk("bp_pc", commit_pc, 32'h400);
        tick(); #1;
        chk_commit("bp_hold", 3, 32'h43);
        chk("bp_count", count, 3);
        commit_ready = 1;
        tick(); #1;
        chk_commit("bp_next", 0, 32'h40);
        chk("bp_next_prd", commit_prd, 21);
        flush_all = 1;
        #1; chk("fa_aready", alloc_ready, 0);
        tick();
        flush_all = 0; commit_ready = 0;
        #1;
        chk("fa_empty", empty, 1);
        chk("fa_count", count, 0);
        chk("fa_cv", commit_valid, 0);
        chk("fa_aidx", alloc_idx, 1);

        // Async reset with live entries
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; alloc_prd = 5'(i); alloc_pc = 32'h600;
            tick();
        end
        alloc_valid = 0;
        wb_set(0, 1, 32'h99);
        tick();
        wb_clear();
        #1;
        chk("ar_cv_pre", commit_valid, 1);
        chk("ar_count_pre", count, 3);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("ar_empty", empty, 1);
        chk("ar_cv", commit_valid, 0);
        chk("ar_count", count, 0);
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("ar_aidx", alloc_idx, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
